// File: rtl/stack_queue_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : stack_queue_buffer
//  Description : Dual-mode LIFO/FIFO operand store. The memory controller
//                pushes switch values and ALU results in and pops operands
//                out. The next two pop candidates are exposed
//                combinationally as ALU operands A/B.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        : system clock, rising edge
//    rst        : asynchronous reset, active low
//    mode       : 1 = stack (LIFO), 0 = queue (FIFO)
//    clear      : synchronous flush of all contents
//    push, pop  : single-cycle write / read strobes
//    din        : word to push
//    dout       : registered popped word, held until the next accepted pop
//    dout_valid : one-cycle pulse, dout was updated by a pop
//    peek0/1    : next / second-next pop candidates (0 when not present)
//    count      : occupancy 0..DEPTH
//    empty/full : occupancy indicators
//    overflow   : one-cycle pulse on a rejected push
//    underflow  : one-cycle pulse on a rejected pop
// ============================================================================
module stack_queue_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [WIDTH-1:0] peek0,
    output logic [WIDTH-1:0] peek1,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);
    localparam logic [AW-1:0] c_ptr_two = AW'(2);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_mode_q;
    // Mode history is meaningless straight out of reset, so the first
    // sampled mode is never treated as a change.
    logic             r_mode_seen;

    logic             w_mode_chg;
    logic             w_flush;
    logic             w_empty;
    logic             w_full;
    logic [AW-1:0]    w_top;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    logic             w_rd_en;
    logic [AW-1:0]    w_rd_addr;
    logic [AW-1:0]    w_wr_ptr_nxt;
    logic [AW-1:0]    w_rd_ptr_nxt;
    logic [AW:0]      w_count_nxt;
    logic             w_ovf;
    logic             w_udf;
    logic [AW-1:0]    w_p0_addr;
    logic [AW-1:0]    w_p1_addr;

    assign w_mode_chg = r_mode_seen && (mode != r_mode_q);
    assign w_flush    = clear | w_mode_chg;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_depth);
    assign w_top      = r_wr_ptr - c_ptr_one;

    always_comb begin
        w_wr_en      = 1'b0;
        w_wr_addr    = r_wr_ptr;
        w_rd_en      = 1'b0;
        w_rd_addr    = r_rd_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        w_ovf        = 1'b0;
        w_udf        = 1'b0;

        if (w_flush) begin
            // Flush silently drops any push/pop in the same cycle.
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else if (push && pop) begin
            if (w_empty) begin
                w_wr_en      = 1'b1;
                w_wr_ptr_nxt = r_wr_ptr + c_ptr_one;
                w_count_nxt  = r_count + c_cnt_one;
                w_udf        = 1'b1;
            end else if (mode) begin
                // Stack: replace the top in place; the old top is read out
                // before the write lands because both happen on the same edge.
                w_wr_en   = 1'b1;
                w_wr_addr = w_top;
                w_rd_en   = 1'b1;
                w_rd_addr = w_top;
            end else begin
                w_wr_en      = 1'b1;
                w_wr_ptr_nxt = r_wr_ptr + c_ptr_one;
                w_rd_en      = 1'b1;
                w_rd_ptr_nxt = r_rd_ptr + c_ptr_one;
            end
        end else if (push) begin
            if (w_full) begin
                w_ovf = 1'b1;
            end else begin
                w_wr_en      = 1'b1;
                w_wr_ptr_nxt = r_wr_ptr + c_ptr_one;
                w_count_nxt  = r_count + c_cnt_one;
            end
        end else if (pop) begin
            if (w_empty) begin
                w_udf = 1'b1;
            end else begin
                w_rd_en     = 1'b1;
                w_count_nxt = r_count - c_cnt_one;
                if (mode) begin
                    w_rd_addr    = w_top;
                    w_wr_ptr_nxt = w_top;
                end else begin
                    w_rd_ptr_nxt = r_rd_ptr + c_ptr_one;
                end
            end
        end
    end

    // Storage carries no reset; contents are only visible through count.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_mode_q     <= 1'b0;
            r_mode_seen  <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_count      <= w_count_nxt;
            r_dout_valid <= w_rd_en;
            r_overflow   <= w_ovf;
            r_underflow  <= w_udf;
            r_mode_q     <= mode;
            r_mode_seen  <= 1'b1;
            if (w_rd_en) begin
                r_dout <= r_mem[w_rd_addr];
            end
        end
    end

    // Peek addressing follows the mode the current contents were built in.
    assign w_p0_addr = r_mode_q ? w_top : r_rd_ptr;
    assign w_p1_addr = r_mode_q ? (r_wr_ptr - c_ptr_two) : (r_rd_ptr + c_ptr_one);

    assign peek0      = (r_count != '0)       ? r_mem[w_p0_addr] : '0;
    assign peek1      = (r_count > c_cnt_one) ? r_mem[w_p1_addr] : '0;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign count      = r_count;
    assign empty      = w_empty;
    assign full       = w_full;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_stack_queue_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_queue_buffer
//  Description : Self-checking bench for stack_queue_buffer: directed vector
//                table, hand-written corner sequences and randomized traffic
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_queue_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode;
    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [WIDTH-1:0] peek0;
    logic [WIDTH-1:0] peek1;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    stack_queue_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .clear      (clear),
        .push       (push),
        .pop        (pop),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .peek0      (peek0),
        .peek1      (peek1),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: contents kept oldest-first; stack pops from the back,
    // queue pops from the front.
    logic [31:0] mq[$];
    logic [31:0] m_dout;
    logic        m_dv, m_ovf, m_udf, m_prev, m_seen;

    typedef struct {
        logic        md, cl, ps, pp;
        logic [31:0] d;
        logic [31:0] p0, p1;
        logic [4:0]  cnt;
        logic [31:0] dt;
        logic        dv, ovf, udf;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic md, input logic cl, input logic ps,
                                input logic pp, input logic [31:0] d,
                                input logic [31:0] p0, input logic [31:0] p1,
                                input logic [4:0] cnt, input logic [31:0] dt,
                                input logic dv, input logic ovf, input logic udf);
        vec_t v;
        v.md = md; v.cl = cl; v.ps = ps; v.pp = pp; v.d = d;
        v.p0 = p0; v.p1 = p1; v.cnt = cnt; v.dt = dt;
        v.dv = dv; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        m_prev = 1'b0; m_seen = 1'b0;
    endtask

    task automatic model_step(input logic md, input logic cl, input logic ps,
                              input logic pp, input logic [31:0] d);
        m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        if (cl || (m_seen && md != m_prev)) begin
            mq.delete();
        end else if (ps && pp) begin
            if (mq.size() == 0) begin
                mq.push_back(d);
                m_udf = 1'b1;
            end else if (md) begin
                m_dout = mq[mq.size()-1];
                mq[mq.size()-1] = d;
                m_dv = 1'b1;
            end else begin
                m_dout = mq.pop_front();
                mq.push_back(d);
                m_dv = 1'b1;
            end
        end else if (ps) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back(d);
        end else if (pp) begin
            if (mq.size() == 0) m_udf = 1'b1;
            else begin
                m_dout = md ? mq.pop_back() : mq.pop_front();
                m_dv = 1'b1;
            end
        end
        m_prev = md;
        m_seen = 1'b1;
    endtask

    function automatic logic [31:0] m_peek(input int k);
        if (mq.size() <= k) return 32'h0;
        return m_prev ? mq[mq.size()-1-k] : mq[k];
    endfunction

    task automatic check_model(input string tag);
        chk({tag, " dout"},       dout,       m_dout);
        chk({tag, " dout_valid"}, {31'b0, dout_valid}, {31'b0, m_dv});
        chk({tag, " peek0"},      peek0,      m_peek(0));
        chk({tag, " peek1"},      peek1,      m_peek(1));
        chk({tag, " count"},      {27'b0, count}, mq.size());
        chk({tag, " empty"},      {31'b0, empty},    {31'b0, (mq.size() == 0)});
        chk({tag, " full"},       {31'b0, full},     {31'b0, (mq.size() == DEPTH)});
        chk({tag, " overflow"},   {31'b0, overflow},  {31'b0, m_ovf});
        chk({tag, " underflow"},  {31'b0, underflow}, {31'b0, m_udf});
    endtask

    // Drive at the falling edge, update the model at the rising edge and
    // leave the caller 1 time unit after that edge to sample.
    task automatic step(input logic md, input logic cl, input logic ps,
                        input logic pp, input logic [31:0] d);
        @(negedge clk);
        mode = md; clear = cl; push = ps; pop = pp; din = d;
        @(posedge clk);
        model_step(md, cl, ps, pp, d);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rm;
        int   pbias;

        // ---------------- reset ----------------
        rst = 1'b0; mode = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset count",      {27'b0, count}, 32'd0);
        chk("reset empty",      {31'b0, empty}, 32'd1);
        chk("reset full",       {31'b0, full},  32'd0);
        chk("reset dout",       dout,           32'd0);
        chk("reset dout_valid", {31'b0, dout_valid}, 32'd0);
        chk("reset peek0",      peek0,          32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // ---------------- directed table: stack then queue ----------------
        tbl[0]  = mk(1'b1,1'b0,1'b1,1'b0,32'h11, 32'h11,32'h00,5'd1, 32'h00,1'b0,1'b0,1'b0);
        tbl[1]  = mk(1'b1,1'b0,1'b1,1'b0,32'h22, 32'h22,32'h11,5'd2, 32'h00,1'b0,1'b0,1'b0);
        tbl[2]  = mk(1'b1,1'b0,1'b1,1'b0,32'h33, 32'h33,32'h22,5'd3, 32'h00,1'b0,1'b0,1'b0);
        tbl[3]  = mk(1'b1,1'b0,1'b0,1'b1,32'h00, 32'h22,32'h11,5'd2, 32'h33,1'b1,1'b0,1'b0);
        tbl[4]  = mk(1'b1,1'b0,1'b0,1'b1,32'h00, 32'h11,32'h00,5'd1, 32'h22,1'b1,1'b0,1'b0);
        tbl[5]  = mk(1'b1,1'b0,1'b0,1'b0,32'h00, 32'h11,32'h00,5'd1, 32'h22,1'b0,1'b0,1'b0);
        tbl[6]  = mk(1'b0,1'b0,1'b0,1'b0,32'h00, 32'h00,32'h00,5'd0, 32'h22,1'b0,1'b0,1'b0);
        tbl[7]  = mk(1'b0,1'b0,1'b1,1'b0,32'h11, 32'h11,32'h00,5'd1, 32'h22,1'b0,1'b0,1'b0);
        tbl[8]  = mk(1'b0,1'b0,1'b1,1'b0,32'h22, 32'h11,32'h22,5'd2, 32'h22,1'b0,1'b0,1'b0);
        tbl[9]  = mk(1'b0,1'b0,1'b1,1'b0,32'h33, 32'h11,32'h22,5'd3, 32'h22,1'b0,1'b0,1'b0);
        tbl[10] = mk(1'b0,1'b0,1'b0,1'b1,32'h00, 32'h22,32'h33,5'd2, 32'h11,1'b1,1'b0,1'b0);
        tbl[11] = mk(1'b0,1'b0,1'b0,1'b1,32'h00, 32'h33,32'h00,5'd1, 32'h22,1'b1,1'b0,1'b0);
        tbl[12] = mk(1'b0,1'b0,1'b0,1'b1,32'h00, 32'h00,32'h00,5'd0, 32'h33,1'b1,1'b0,1'b0);
        tbl[13] = mk(1'b0,1'b0,1'b0,1'b1,32'h00, 32'h00,32'h00,5'd0, 32'h33,1'b0,1'b0,1'b1);
        tbl[14] = mk(1'b0,1'b0,1'b0,1'b0,32'h00, 32'h00,32'h00,5'd0, 32'h33,1'b0,1'b0,1'b0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].md, tbl[i].cl, tbl[i].ps, tbl[i].pp, tbl[i].d);
            chk($sformatf("tbl%0d peek0", i), peek0, tbl[i].p0);
            chk($sformatf("tbl%0d peek1", i), peek1, tbl[i].p1);
            chk($sformatf("tbl%0d count", i), {27'b0, count}, {27'b0, tbl[i].cnt});
            chk($sformatf("tbl%0d dout", i),  dout,  tbl[i].dt);
            chk($sformatf("tbl%0d dout_valid", i), {31'b0, dout_valid}, {31'b0, tbl[i].dv});
            chk($sformatf("tbl%0d overflow", i),   {31'b0, overflow},   {31'b0, tbl[i].ovf});
            chk($sformatf("tbl%0d underflow", i),  {31'b0, underflow},  {31'b0, tbl[i].udf});
            chk($sformatf("tbl%0d empty", i), {31'b0, empty}, {31'b0, (tbl[i].cnt == 5'd0)});
        end

        // ---------------- queue wrap-around ----------------
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, i);
            check_model("wrap fill");
        end
        for (int i = 12; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, i);
            chk("wrap pushpop dout", dout, i - 12);
            chk("wrap overflow", {31'b0, overflow}, 32'd0);
            check_model("wrap pushpop");
        end
        for (int i = 8; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            chk("wrap drain dout", dout, i);
            check_model("wrap drain");
        end

        // ---------------- stack fill / overflow / replace-top ----------------
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 32'h100 + i);
        end
        chk("fill full", {31'b0, full}, 32'd1);
        check_model("fill");
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'hBB);
        chk("fill17 overflow", {31'b0, overflow}, 32'd1);
        chk("fill17 count", {27'b0, count}, 32'd16);
        check_model("fill17");
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'hAA);
        chk("replace dout",  dout,  32'h10F);
        chk("replace peek0", peek0, 32'hAA);
        chk("replace peek1", peek1, 32'h10E);
        chk("replace count", {27'b0, count}, 32'd16);
        check_model("replace");
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("overflow pulse end", {31'b0, overflow}, 32'd0);

        // ---------------- mode toggle and clear ----------------
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h50 + i);
        check_model("toggle pre");
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("toggle count", {27'b0, count}, 32'd0);
        chk("toggle empty", {31'b0, empty}, 32'd1);
        chk("toggle dout_valid", {31'b0, dout_valid}, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h77);
        chk("clear+push count", {27'b0, count}, 32'd0);
        chk("clear+push overflow", {31'b0, overflow}, 32'd0);
        check_model("clear");

        // ---------------- asynchronous reset mid-burst ----------------
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h60 + i);
        check_model("burst");
        @(negedge clk);
        #1 rst = 1'b0;
        model_reset();
        #1;
        chk("async count", {27'b0, count}, 32'd0);
        chk("async empty", {31'b0, empty}, 32'd1);
        chk("async dout",  dout,  32'd0);
        chk("async peek0", peek0, 32'd0);
        check_model("async");
        @(negedge clk);
        push = 1'b0;
        rst  = 1'b1;
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h5);
        chk("post-reset peek0", peek0, 32'h5);
        chk("post-reset count", {27'b0, count}, 32'd1);
        check_model("post-reset");

        // ---------------- randomized traffic ----------------
        rm = 1'b1;
        for (int i = 0; i < 600; i++) begin
            pbias = ((i / 60) % 2 == 0) ? 70 : 35;
            if ($urandom_range(0, 39) == 0) rm = ~rm;
            step(rm,
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 99) < pbias),
                 ($urandom_range(0, 99) < (100 - pbias)),
                 $urandom());
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
